// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state doubleword data memory responder for a pipeline memory stage
// IDLE/WAIT/RESP handshake in front of a DEPTH x 64-bit array with alignment, range and double-op faulting.

module data_mem_responder #(
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [63:0] Address,
   input  logic [63:0] DataWrite,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [63:0] DataRead,
   output logic        Ready,
   output logic        Busy,
   output logic        Error
);
   localparam int         AW = $clog2(DEPTH);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [63:0]   r_addr;
   logic [63:0]   r_wdata;
   logic [63:0]   r_data_read;
   logic          r_rd;
   logic          r_wr;
   logic          r_ready;
   logic          r_error;
   logic [63:0]   r_mem [DEPTH];

   logic          w_req;
   logic          w_idle;
   logic [63:0]   w_op_addr;
   logic [63:0]   w_op_wdata;
   logic          w_op_rd;
   logic          w_op_wr;
   logic          w_fault;
   logic          w_enter_resp;
   logic [AW-1:0] w_idx;

   assign w_req  = MemRead | MemWrite;
   assign w_idle = (r_state == IDLE);

   // With zero wait states the response is resolved on the acceptance edge, so the live inputs stand in for the latches.
   assign w_op_addr  = w_idle ? Address   : r_addr;
   assign w_op_wdata = w_idle ? DataWrite : r_wdata;
   assign w_op_rd    = w_idle ? MemRead   : r_rd;
   assign w_op_wr    = w_idle ? MemWrite  : r_wr;

   assign w_idx   = w_op_addr[AW+2:3];
   assign w_fault = (|w_op_addr[2:0]) | (|w_op_addr[63:AW+3]) | (w_op_rd & w_op_wr);

   assign w_enter_resp = w_idle ? (w_req && (WC == 4'd0))
                                : ((r_state == WAIT) && (r_cnt <= 4'd1));

   assign Busy     = (w_idle & w_req) | (r_state == WAIT);
   assign Ready    = r_ready;
   assign Error    = r_error;
   assign DataRead = r_data_read;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_cnt       <= 4'd0;
         r_addr      <= 64'd0;
         r_wdata     <= 64'd0;
         r_rd        <= 1'b0;
         r_wr        <= 1'b0;
         r_ready     <= 1'b0;
         r_error     <= 1'b0;
         r_data_read <= 64'd0;
      end else begin
         r_ready <= 1'b0;
         r_error <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_addr  <= Address;
                  r_wdata <= DataWrite;
                  r_rd    <= MemRead;
                  r_wr    <= MemWrite;
                  r_cnt   <= WC;
                  r_state <= (WC == 4'd0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= RESP;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (w_enter_resp) begin
            r_ready <= 1'b1;
            r_error <= w_fault;
            if (w_fault) begin
               r_data_read <= 64'd0;
            end else if (w_op_rd) begin
               r_data_read <= r_mem[w_idx];
            end
         end
      end
   end

   // Writes land on the same edge that raises Ready, so a read issued next sees them.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= 64'd0;
         end
      end else if (w_enter_resp && w_op_wr && !w_fault) begin
         r_mem[w_idx] <= w_op_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
// Drives one stimulus stream into a 2-wait-state and a 0-wait-state instance and checks both against a memory model.

module tb_data_mem_responder;
   logic        clk = 1'b0;
   logic        Reset;
   logic        MemRead;
   logic        MemWrite;
   logic [63:0] Address;
   logic [63:0] DataWrite;
   logic [63:0] DataRead2, DataRead0;
   logic        Ready2, Busy2, Error2;
   logic        Ready0, Busy0, Error0;

   int          checks   = 0;
   int          failures = 0;

   logic [63:0] m_mem [32];
   logic [63:0] m_dr;

   int          lat2, lat0, busy2, busy0;
   logic        err2, err0, pulse_ok;
   logic [63:0] dr2, dr0;

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .Reset(Reset), .Address(Address), .DataWrite(DataWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .DataRead(DataRead2),
      .Ready(Ready2), .Busy(Busy2), .Error(Error2)
   );

   data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .Reset(Reset), .Address(Address), .DataWrite(DataWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .DataRead(DataRead0),
      .Ready(Ready0), .Busy(Busy0), .Error(Error0)
   );

   function automatic void model_clear();
      for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
      m_dr = 64'd0;
   endfunction

   function automatic logic model_op(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
      logic bad;
      bad = (addr % 64'd8 != 64'd0) || (addr >= 64'd256) || (rd && wr);
      if (bad)     m_dr = 64'd0;
      else if (wr) m_mem[int'(addr / 64'd8)] = wdata;
      else         m_dr = m_mem[int'(addr / 64'd8)];
      return bad;
   endfunction

   task automatic run_op(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] wdata);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Address = addr; DataWrite = wdata;
      lat2 = -1; lat0 = -1; err2 = 1'bx; err0 = 1'bx; dr2 = 'x; dr0 = 'x; pulse_ok = 1'b1;
      #1;
      busy2 = int'(Busy2); busy0 = int'(Busy0);
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; Address = {$urandom, $urandom}; DataWrite = {$urandom, $urandom};
      for (int c = 1; c <= 20 && (lat2 < 0 || lat0 < 0); c++) begin
         #1;
         busy2 += int'(Busy2); busy0 += int'(Busy0);
         if ((Error2 && !Ready2) || (Error0 && !Ready0)) pulse_ok = 1'b0;
         if (lat2 < 0 && Ready2) begin
            lat2 = c; err2 = Error2; dr2 = DataRead2;
            if (Busy2) pulse_ok = 1'b0;
         end else if (Ready2) pulse_ok = 1'b0;
         if (lat0 < 0 && Ready0) begin
            lat0 = c; err0 = Error0; dr0 = DataRead0;
            if (Busy0) pulse_ok = 1'b0;
         end else if (Ready0) pulse_ok = 1'b0;
         @(negedge clk);
      end
      #1;
      if (Ready2 || Ready0 || Error2 || Error0 || Busy2 || Busy0) pulse_ok = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      MemRead = 1'b0; MemWrite = 1'b0; Reset = 1'b1;
      #1;
      checks++;
      if ({Ready2, Error2, Busy2, DataRead2, Ready0, Error0, Busy0, DataRead0} !== 134'd0) begin
         failures++;
         $display("FAIL reset_state got r/e/b=%b%b%b dr2=%h r/e/b0=%b%b%b dr0=%h want all zero",
                  Ready2, Error2, Busy2, DataRead2, Ready0, Error0, Busy0, DataRead0);
      end
      MemRead = 1'b1;
      #1;
      checks++;
      if ({Busy2, Busy0, Ready2, Ready0} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_busy got busy2=%b busy0=%b ready2=%b ready0=%b want 1 1 0 0", Busy2, Busy0, Ready2, Ready0);
      end
      @(negedge clk);
      MemRead = 1'b0; Reset = 1'b0;
      model_clear();
   endtask

   task automatic test_write_read;
      logic e;
      e = model_op(1'b0, 1'b1, 64'h18, 64'hDEADBEEF_01234567);
      run_op(1'b0, 1'b1, 64'h18, 64'hDEADBEEF_01234567);
      checks++;
      if (lat2 !== 3 || lat0 !== 1 || err2 !== 1'b0 || err0 !== 1'b0) begin
         failures++;
         $display("FAIL wr_0x18 got lat2=%0d lat0=%0d err=%b%b want 3 1 00", lat2, lat0, err2, err0);
      end
      e = model_op(1'b1, 1'b0, 64'h18, 64'd0);
      run_op(1'b1, 1'b0, 64'h18, 64'd0);
      checks++;
      if (lat2 !== 3 || lat0 !== 1 || err2 !== 1'b0 || dr2 !== 64'hDEADBEEF_01234567 || dr0 !== 64'hDEADBEEF_01234567) begin
         failures++;
         $display("FAIL rd_0x18 got lat2=%0d lat0=%0d err2=%b dr2=%h dr0=%h want 3 1 0 deadbeef01234567", lat2, lat0, err2, dr2, dr0);
      end
   endtask

   task automatic test_misaligned;
      logic e;
      e = model_op(1'b1, 1'b0, 64'h1C, 64'd0);
      run_op(1'b1, 1'b0, 64'h1C, 64'd0);
      checks++;
      if (err2 !== 1'b1 || err0 !== 1'b1 || dr2 !== 64'd0 || dr0 !== 64'd0 || lat2 !== 3) begin
         failures++;
         $display("FAIL misaligned got err=%b%b dr2=%h dr0=%h lat2=%0d want err 11 data 0 lat 3", err2, err0, dr2, dr0, lat2);
      end
      e = model_op(1'b1, 1'b0, 64'h18, 64'd0);
      run_op(1'b1, 1'b0, 64'h18, 64'd0);
      checks++;
      if (dr2 !== 64'hDEADBEEF_01234567 || dr0 !== 64'hDEADBEEF_01234567) begin
         failures++;
         $display("FAIL misaligned_keep got dr2=%h dr0=%h want deadbeef01234567", dr2, dr0);
      end
   endtask

   task automatic test_fault_ops;
      logic e;
      e = model_op(1'b0, 1'b1, 64'h100, 64'hA5A5_A5A5_A5A5_A5A5);
      run_op(1'b0, 1'b1, 64'h100, 64'hA5A5_A5A5_A5A5_A5A5);
      checks++;
      if (err2 !== 1'b1 || err0 !== 1'b1 || dr2 !== 64'd0) begin
         failures++;
         $display("FAIL out_of_range got err=%b%b dr2=%h want err 11 data 0", err2, err0, dr2);
      end
      e = model_op(1'b1, 1'b1, 64'h08, 64'h1234_5678_9ABC_DEF0);
      run_op(1'b1, 1'b1, 64'h08, 64'h1234_5678_9ABC_DEF0);
      checks++;
      if (err2 !== 1'b1 || err0 !== 1'b1 || dr0 !== 64'd0) begin
         failures++;
         $display("FAIL double_op got err=%b%b dr0=%h want err 11 data 0", err2, err0, dr0);
      end
      for (int a = 0; a < 2; a++) begin
         e = model_op(1'b1, 1'b0, 64'(a * 8), 64'd0);
         run_op(1'b1, 1'b0, 64'(a * 8), 64'd0);
         checks++;
         if (dr2 !== 64'd0 || dr0 !== 64'd0 || err2 !== 1'b0) begin
            failures++;
            $display("FAIL fault_no_write addr=%0h got dr2=%h dr0=%h err2=%b want 0 0 0", a * 8, dr2, dr0, err2);
         end
      end
   endtask

   task automatic test_busy;
      logic e;
      e = model_op(1'b1, 1'b0, 64'h18, 64'd0);
      run_op(1'b1, 1'b0, 64'h18, 64'd0);
      checks++;
      if (busy2 !== 3 || busy0 !== 1 || !pulse_ok) begin
         failures++;
         $display("FAIL busy_profile got busy2=%0d busy0=%0d pulse_ok=%b want 3 1 1", busy2, busy0, pulse_ok);
      end
   endtask

   task automatic test_mid_reset;
      int   rcount;
      logic e;
      @(negedge clk);
      MemWrite = 1'b1; Address = 64'h10; DataWrite = 64'h55;
      @(negedge clk);
      MemWrite = 1'b0;
      Reset = 1'b1;
      rcount = 0;
      for (int c = 0; c < 7; c++) begin
         #1;
         rcount += int'(Ready2);
         @(negedge clk);
         if (c == 1) Reset = 1'b0;
      end
      checks++;
      if (rcount !== 0) begin
         failures++;
         $display("FAIL mid_reset_ready got pulses=%0d want 0", rcount);
      end
      model_clear();
      e = model_op(1'b1, 1'b0, 64'h10, 64'd0);
      run_op(1'b1, 1'b0, 64'h10, 64'd0);
      checks++;
      if (dr2 !== 64'd0 || dr0 !== 64'd0 || err2 !== 1'b0 || lat2 !== 3) begin
         failures++;
         $display("FAIL mid_reset_read got dr2=%h dr0=%h err2=%b lat2=%0d want 0 0 0 3", dr2, dr0, err2, lat2);
      end
   endtask

   task automatic test_back_to_back;
      logic e, exp_r0, exp_r2;
      logic [63:0] v;
      for (int a = 0; a < 2; a++) begin
         v = {$urandom, $urandom};
         e = model_op(1'b0, 1'b1, 64'(a * 8), v);
         run_op(1'b0, 1'b1, 64'(a * 8), v);
      end
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         MemRead = 1'b1; Address = 64'(((j / 2) % 2) * 8);
         #1;
         exp_r0 = (j % 2 == 1);
         exp_r2 = (j % 4 == 3);
         checks++;
         if ({Ready0, Busy0, Ready2, Busy2} !== {exp_r0, !exp_r0, exp_r2, !exp_r2}) begin
            failures++;
            $display("FAIL b2b_handshake j=%0d got r0 b0 r2 b2=%b%b%b%b want %b%b%b%b",
                     j, Ready0, Busy0, Ready2, Busy2, exp_r0, !exp_r0, exp_r2, !exp_r2);
         end
         if (exp_r0) begin
            checks++;
            if (DataRead0 !== m_mem[((j - 1) / 2) % 2]) begin
               failures++;
               $display("FAIL b2b_data0 j=%0d got %h want %h", j, DataRead0, m_mem[((j - 1) / 2) % 2]);
            end
         end
         if (exp_r2) begin
            checks++;
            if (DataRead2 !== m_mem[0]) begin
               failures++;
               $display("FAIL b2b_data2 j=%0d got %h want %h", j, DataRead2, m_mem[0]);
            end
         end
      end
      MemRead = 1'b0;
      repeat (6) @(negedge clk);
      e = model_op(1'b1, 1'b0, 64'h00, 64'd0);
      run_op(1'b1, 1'b0, 64'h00, 64'd0);
   endtask

   task automatic test_random;
      logic        e, rd, wr;
      logic [63:0] addr, wdata;
      int          kind, op;
      for (int n = 0; n < 60; n++) begin
         kind  = int'($urandom_range(0, 7));
         op    = int'($urandom_range(0, 9));
         addr  = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
         if (kind == 5) addr = addr | 64'($urandom_range(1, 7));
         if (kind == 6) addr = addr | (64'd1 << $urandom_range(8, 63));
         if (kind == 7) addr = {59'd0, 2'($urandom_range(0, 3)), 3'b000};
         rd    = (op <= 4) || (op == 9);
         wr    = (op >= 5);
         wdata = {$urandom, $urandom};
         e = model_op(rd, wr, addr, wdata);
         run_op(rd, wr, addr, wdata);
         checks++;
         if (lat2 !== 3 || lat0 !== 1) begin
            failures++;
            $display("FAIL rand_latency n=%0d got lat2=%0d lat0=%0d want 3 1", n, lat2, lat0);
         end
         checks++;
         if (err2 !== e || err0 !== e) begin
            failures++;
            $display("FAIL rand_error n=%0d addr=%h rd=%b wr=%b got err=%b%b want %b", n, addr, rd, wr, err2, err0, e);
         end
         checks++;
         if (dr2 !== m_dr || dr0 !== m_dr) begin
            failures++;
            $display("FAIL rand_data n=%0d addr=%h got dr2=%h dr0=%h want %h", n, addr, dr2, dr0, m_dr);
         end
         checks++;
         if (busy2 !== 3 || busy0 !== 1) begin
            failures++;
            $display("FAIL rand_busy n=%0d got busy2=%0d busy0=%0d want 3 1", n, busy2, busy0);
         end
         checks++;
         if (!pulse_ok) begin
            failures++;
            $display("FAIL rand_pulse n=%0d got pulse_ok=0 want 1", n);
         end
      end
   endtask

   initial begin
      Reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Address = 64'd0; DataWrite = 64'd0;
      model_clear();
      test_reset();
      test_write_read();
      test_misaligned();
      test_fault_ops();
      test_busy();
      test_mid_reset();
      test_back_to_back();
      test_random();
      test_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
